pixel_readout: RTL and testbench
================================

Name: pixel_readout

Overview:
Receiving end of the exposure/readout control interface driven by RE_control.
- Follows the erase/expose/ADC/NRE_1/NRE_2 sequence produced by the exposure controller.
- Captures converted values of the 2x2 pixel array, one row per NRE strobe.
- Streams the four pixels, in raster order, over a valid/ready interface to the downstream frame consumer.
- Flags protocol violations and frames that arrive before the previous frame has drained.

Parameters:
DATA_W, 8, bits per pixel sample
COLS, 2, pixels per row (adc_data carries one full row); row count is fixed at 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
erase  in  1  pixel erase phase from exposure controller (active high)
expose  in  1  exposure phase (active high)
ADC  in  1  conversion phase (active high)
NRE_1  in  1  row 1 read enable, active low
NRE_2  in  1  row 2 read enable, active low
adc_data  in  COLS*DATA_W  row sample; column 0 in the LSBs; valid while the NRE of that row is low
pix_data  out  DATA_W  output pixel
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accepts a pixel when pix_valid&&pix_ready
frame_start  out  1  high with the first pixel (r0c0) of a frame, while it is presented
frame_done  out  1  one-cycle pulse on acceptance of the last pixel (r1c1)
overrun  out  1  sticky: a frame was dropped because the buffer was not drained
proto_err  out  1  sticky: illegal strobe ordering or overlap

Behaviour:
- Reset (synchronous, active-high, clk): all outputs 0, state IDLE, buffer cleared, edge registers for NRE_1/NRE_2 loaded with 1.
- NRE falling edge: previous registered value 1, current value 0. Capture adc_data on the edge cycle only, never on later low cycles.
- FSM states:
  - IDLE -> ARMED on erase=1.
  - ARMED -> ROW1 on a NRE_1 fall, capturing row 0.
  - ROW1 -> DRAIN on a NRE_2 fall, capturing row 1.
  - DRAIN -> IDLE after r1c1 is accepted.
- expose and ADC are phase qualifiers only. A NRE fall while expose=1 sets proto_err and is ignored.
- Ordering errors:
  - NRE_2 fall in ARMED (before row 1) sets proto_err and is ignored.
  - NRE_1 fall in ROW1 recaptures row 0 and sets proto_err.
- Simultaneous NRE_1 and NRE_2 falls in the same cycle: both ignored, proto_err set.
- erase=1 in ROW1 aborts the partial frame: row 0 is cleared and the FSM returns to ARMED.
- erase in DRAIN does not abort. It marks the next frame pending; the FSM goes to ARMED after the drain completes.
- NRE_1 fall in DRAIN: the frame is dropped (no capture), overrun is set, and the FSM stays in DRAIN.
- Latency: row-1 capture at edge cycle t gives pix_valid=1 with r0c0 at t+1.
- Output order: r0c0, r0c1, r1c0, r1c1, one per accepted cycle. With pix_ready held high, all 4 pixels are out by t+4.
- Handshake:
  - pix_data and pix_valid hold stable while pix_valid&&!pix_ready.
  - pix_valid never drops without acceptance except on reset.
- A 2-bit pixel index wraps 3->0 on the last acceptance. frame_done pulses in that same cycle.
- overrun and proto_err clear only on reset.
- Reset mid-drain discards the buffered frame without any frame_done.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ARMED, ROW1, DRAIN).
  - ROWS=2 constant.
  - Pixel index width (clog2(ROWS*COLS)).
- One sub-module, nre_edge_detect: registered falling-edge detector, instantiated once per NRE line. Reset value 1, so a low NRE at reset release does not produce an edge.
- Frame buffer and output mux stay inline.

Test Plan:
1. Nominal frame, DATA_W=8, pix_ready=1: erase, expose, ADC, then NRE_1 low with adc_data=16'h2211, then NRE_2 low with 16'h4433 -> pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting one cycle after the NRE_2 edge; frame_start on 0x11; frame_done with 0x44.
2. Backpressure: same frame, pix_ready toggling 1,0,0,1,... -> each pixel held stable while stalled; sequence unchanged; exactly one frame_done.
3. Overrun: hold pix_ready=0 after the frame, then issue a second erase and NRE_1 -> overrun=1; the original 4 pixels still drain intact when pix_ready=1.
4. Protocol errors: NRE_2 before NRE_1 -> proto_err=1, no pixels out. After reset, NRE_1 and NRE_2 falling in the same cycle -> proto_err=1, no capture.
5. Abort: erase reasserted between the NRE_1 and NRE_2 edges -> no output; a subsequent full sequence with 16'hBBAA/16'hDDCC yields only 0xAA, 0xBB, 0xCC, 0xDD.
6. Reset mid-drain after 2 pixels accepted -> all outputs 0 the next cycle, no frame_done; the next frame is delivered correctly.

Source files
------------

// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the 2-row pixel readout block.
package pixel_readout_pkg;

  localparam int unsigned ROWS = 2;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRow1,
    StDrain
  } state_e;

  function automatic int unsigned pix_idx_w(int unsigned cols);
    return (ROWS * cols > 1) ? $clog2(ROWS * cols) : 1;
  endfunction

endpackage

// File: rtl/nre_edge_detect.sv
// Registered falling-edge detector for an active-low read-enable strobe.
module nre_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic nre_i,
  output logic fall_o
);

  logic nre_q;

  // Resets high so a line already low at reset release is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nre_q <= 1'b1;
    end else begin
      nre_q <= nre_i;
    end
  end

  assign fall_o = nre_q & ~nre_i;

endmodule

// File: rtl/pixel_readout.sv
// Captures two ADC rows on NRE strobes and streams the 2xCOLS frame over valid/ready.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COLS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   erase,
  input  logic                   expose,
  input  logic                   ADC,
  input  logic                   NRE_1,
  input  logic                   NRE_2,
  input  logic [COLS*DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0]      pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   proto_err
);

  localparam int unsigned IdxW = pix_idx_w(COLS);
  localparam int unsigned NPix = ROWS * COLS;
  localparam int unsigned RowW = COLS * DATA_W;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RowW-1:0]   row0_q, row0_d;
  logic [RowW-1:0]   row1_q, row1_d;
  logic              valid_q, valid_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              proto_q, proto_d;

  logic fall1, fall2;
  logic ev1, ev2;
  logic accept, last;
  logic [DATA_W-1:0] pix_arr [NPix];

  // ADC only marks the conversion phase; nothing here depends on it.
  logic unused_adc;
  assign unused_adc = ADC;

  nre_edge_detect u_nre1 (
    .clk_i   (clk),
    .reset_i (reset),
    .nre_i   (NRE_1),
    .fall_o  (fall1)
  );

  nre_edge_detect u_nre2 (
    .clk_i   (clk),
    .reset_i (reset),
    .nre_i   (NRE_2),
    .fall_o  (fall2)
  );

  // A strobe counts only if it falls alone and outside the exposure phase.
  assign ev1    = fall1 & ~fall2 & ~expose;
  assign ev2    = fall2 & ~fall1 & ~expose;
  assign accept = valid_q & pix_ready;
  assign last   = accept && (idx_q == IdxW'(NPix - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    proto_d   = proto_q;

    if ((fall1 || fall2) && ((fall1 && fall2) || expose)) begin
      proto_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (erase) state_d = StArmed;
      end
      StArmed: begin
        if (ev1) begin
          row0_d  = adc_data;
          state_d = StRow1;
        end else if (ev2) begin
          proto_d = 1'b1;
        end
      end
      StRow1: begin
        if (erase) begin
          row0_d  = '0;
          state_d = StArmed;
        end else if (ev1) begin
          row0_d  = adc_data;
          proto_d = 1'b1;
        end else if (ev2) begin
          row1_d  = adc_data;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (erase) pending_d = 1'b1;
        if (ev1) overrun_d = 1'b1;
        if (last) begin
          idx_d     = '0;
          valid_d   = 1'b0;
          pending_d = 1'b0;
          state_d   = (pending_q || erase) ? StArmed : StIdle;
        end else if (accept) begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      row0_q    <= '0;
      row1_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      proto_q   <= proto_d;
    end
  end

  // Raster order: row 0 columns first, then row 1.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign pix_arr[c]        = row0_q[c*DATA_W +: DATA_W];
    assign pix_arr[COLS + c] = row1_q[c*DATA_W +: DATA_W];
  end

  assign pix_data    = pix_arr[idx_q];
  assign pix_valid   = valid_q;
  assign frame_start = valid_q && (idx_q == '0);
  assign frame_done  = last;
  assign overrun     = overrun_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed self-checking bench for pixel_readout.
module tb_pixel_readout;

  logic        clk;
  logic        reset;
  logic        erase;
  logic        expose;
  logic        ADC;
  logic        NRE_1;
  logic        NRE_2;
  logic [15:0] adc_data;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_start;
  logic        frame_done;
  logic        overrun;
  logic        proto_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] bp_exp [10];

  pixel_readout #(
    .DATA_W (8),
    .COLS   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .erase       (erase),
    .expose      (expose),
    .ADC         (ADC),
    .NRE_1       (NRE_1),
    .NRE_2       (NRE_2),
    .adc_data    (adc_data),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_erase();
    erase = 1'b1;
    tick();
    erase = 1'b0;
  endtask

  // Full control sequence; returns one cycle after the NRE_2 edge.
  task automatic load_frame(input logic [15:0] r0, input logic [15:0] r1);
    pulse_erase();
    expose = 1'b1;
    tick();
    expose = 1'b0;
    ADC = 1'b1;
    tick();
    ADC = 1'b0;
    NRE_1 = 1'b0;
    adc_data = r0;
    tick();
    adc_data = 16'hEEEE;
    tick();
    NRE_1 = 1'b1;
    tick();
    NRE_2 = 1'b0;
    adc_data = r1;
    #1;
    chk("lat_pre_valid", {31'b0, pix_valid}, 32'd0);
    tick();
    NRE_2 = 1'b1;
    adc_data = 16'h0;
  endtask

  task automatic drain4(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] e [4];
    e[0] = d0;
    e[1] = d1;
    e[2] = d2;
    e[3] = d3;
    for (int i = 0; i < 4; i++) begin
      pix_ready = 1'b1;
      #1;
      chk({tag, "_valid"}, {31'b0, pix_valid}, 32'd1);
      chk({tag, "_data"}, {24'b0, pix_data}, {24'b0, e[i]});
      chk({tag, "_start"}, {31'b0, frame_start}, (i == 0) ? 32'd1 : 32'd0);
      chk({tag, "_done"}, {31'b0, frame_done}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk({tag, "_end_valid"}, {31'b0, pix_valid}, 32'd0);
    chk({tag, "_end_done"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    erase     = 1'b0;
    expose    = 1'b0;
    ADC       = 1'b0;
    NRE_1     = 1'b1;
    NRE_2     = 1'b1;
    adc_data  = 16'h0;
    pix_ready = 1'b1;
    bp_exp = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44};

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", {31'b0, pix_valid}, 32'd0);
    chk("rst_data", {24'b0, pix_data}, 32'd0);
    chk("rst_start", {31'b0, frame_start}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_proto", {31'b0, proto_err}, 32'd0);

    // 1. Nominal frame
    load_frame(16'h2211, 16'h4433);
    drain4("nom", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("nom_proto", {31'b0, proto_err}, 32'd0);
    chk("nom_overrun", {31'b0, overrun}, 32'd0);

    // 2. Backpressure, ready pattern 1,0,0,1,...
    load_frame(16'h2211, 16'h4433);
    for (int k = 0; k < 10; k++) begin
      pix_ready = (k % 3 == 0);
      #1;
      chk("bp_valid", {31'b0, pix_valid}, 32'd1);
      chk("bp_data", {24'b0, pix_data}, {24'b0, bp_exp[k]});
      chk("bp_start", {31'b0, frame_start}, (k == 0) ? 32'd1 : 32'd0);
      chk("bp_done", {31'b0, frame_done}, (k == 9) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("bp_end_valid", {31'b0, pix_valid}, 32'd0);
    pix_ready = 1'b1;

    // 3. Overrun: new frame arrives while stalled
    pix_ready = 1'b0;
    load_frame(16'h2211, 16'h4433);
    #1;
    chk("ovr_hold_data0", {24'b0, pix_data}, 32'h11);
    erase = 1'b1;
    tick();
    erase = 1'b0;
    NRE_1 = 1'b0;
    adc_data = 16'hEEFF;
    tick();
    NRE_1 = 1'b1;
    adc_data = 16'h0;
    #1;
    chk("ovr_flag", {31'b0, overrun}, 32'd1);
    chk("ovr_proto", {31'b0, proto_err}, 32'd0);
    chk("ovr_hold_valid", {31'b0, pix_valid}, 32'd1);
    chk("ovr_hold_data1", {24'b0, pix_data}, 32'h11);
    drain4("ovr", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);
    // Erase during drain left the block armed: no new erase needed
    NRE_1 = 1'b0;
    adc_data = 16'h6655;
    tick();
    NRE_1 = 1'b1;
    tick();
    NRE_2 = 1'b0;
    adc_data = 16'h8877;
    tick();
    NRE_2 = 1'b1;
    drain4("pend", 8'h55, 8'h66, 8'h77, 8'h88);

    // 4a. NRE_2 before NRE_1
    do_reset();
    #1;
    chk("pe_rst_overrun", {31'b0, overrun}, 32'd0);
    pulse_erase();
    NRE_2 = 1'b0;
    adc_data = 16'h1234;
    tick();
    NRE_2 = 1'b1;
    tick();
    tick();
    #1;
    chk("pe_order_proto", {31'b0, proto_err}, 32'd1);
    chk("pe_order_valid", {31'b0, pix_valid}, 32'd0);

    // 4b. Simultaneous falls
    do_reset();
    #1;
    chk("pe_rst_proto", {31'b0, proto_err}, 32'd0);
    pulse_erase();
    NRE_1 = 1'b0;
    NRE_2 = 1'b0;
    adc_data = 16'h5678;
    tick();
    NRE_1 = 1'b1;
    NRE_2 = 1'b1;
    tick();
    tick();
    #1;
    chk("pe_both_proto", {31'b0, proto_err}, 32'd1);
    chk("pe_both_valid", {31'b0, pix_valid}, 32'd0);

    // 4c. Strobe during exposure is ignored
    do_reset();
    pulse_erase();
    expose = 1'b1;
    NRE_1 = 1'b0;
    adc_data = 16'h9999;
    tick();
    expose = 1'b0;
    NRE_1 = 1'b1;
    tick();
    #1;
    chk("pe_exp_proto", {31'b0, proto_err}, 32'd1);
    NRE_2 = 1'b0;
    tick();
    NRE_2 = 1'b1;
    tick();
    #1;
    chk("pe_exp_valid", {31'b0, pix_valid}, 32'd0);
    load_frame(16'h2211, 16'h4433);
    drain4("pe_exp", 8'h11, 8'h22, 8'h33, 8'h44);

    // 5. Abort between rows
    do_reset();
    pulse_erase();
    NRE_1 = 1'b0;
    adc_data = 16'h9988;
    tick();
    NRE_1 = 1'b1;
    tick();
    pulse_erase();
    NRE_2 = 1'b0;
    adc_data = 16'h7766;
    tick();
    NRE_2 = 1'b1;
    tick();
    #1;
    chk("abort_valid", {31'b0, pix_valid}, 32'd0);
    chk("abort_proto", {31'b0, proto_err}, 32'd1);
    load_frame(16'hBBAA, 16'hDDCC);
    drain4("abort", 8'hAA, 8'hBB, 8'hCC, 8'hDD);

    // 6. Reset mid-drain after two acceptances
    do_reset();
    pix_ready = 1'b1;
    load_frame(16'h2211, 16'h4433);
    #1;
    chk("mrst_d0", {24'b0, pix_data}, 32'h11);
    tick();
    #1;
    chk("mrst_d1", {24'b0, pix_data}, 32'h22);
    tick();
    reset = 1'b1;
    tick();
    #1;
    chk("mrst_valid", {31'b0, pix_valid}, 32'd0);
    chk("mrst_data", {24'b0, pix_data}, 32'd0);
    chk("mrst_start", {31'b0, frame_start}, 32'd0);
    chk("mrst_done", {31'b0, frame_done}, 32'd0);
    chk("mrst_overrun", {31'b0, overrun}, 32'd0);
    chk("mrst_proto", {31'b0, proto_err}, 32'd0);
    reset = 1'b0;
    tick();
    #1;
    chk("mrst_post_valid", {31'b0, pix_valid}, 32'd0);
    chk("mrst_post_done", {31'b0, frame_done}, 32'd0);
    load_frame(16'h0201, 16'h0403);
    drain4("mrst", 8'h01, 8'h02, 8'h03, 8'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
